// File: rtl/fetch_ctrl.sv
// Next-PC arbiter and fetch sequencer: owns the PC, drives the imem request and flush strobes.
// Optional FETCH_PERF_EN adds fetchCount/redirectCount performance counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        weFromHazard,
  input  logic        pcSrc,
  input  logic [31:0] pcBranch,
  input  logic        jump,
  input  logic [31:0] pcJump,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  output logic [31:0] pc,
  output logic        fetchValid,
  output logic        flushIfId,
  output logic        flushIdEx,
  output logic [1:0]  dbgState
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] redirectCount
`endif
);

  // Handshake: imemReq/imemAddr stay stable until a cycle with imemReady=1 completes the request.
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_MISS  = 2'd2
  } state_t;

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, w_next_pc;
  logic        r_pend_valid, w_next_pend_valid;
  logic        r_pend_br, w_next_pend_br;
  logic [31:0] r_pend_pc, w_next_pend_pc;

  logic        w_req, w_fv, w_accept, w_jump_ok;
  logic [31:0] w_tgt, w_step;

  assign w_jump_ok = jump & weFromHazard;
  assign w_tgt     = pcSrc ? (pcBranch & 32'hFFFF_FFFC) : (pcJump & 32'hFFFF_FFFC);
  assign w_step    = r_pc + 32'(PC_STEP);

  always_comb begin
    w_next_state      = r_state;
    w_next_pc         = r_pc;
    w_next_pend_valid = r_pend_valid;
    w_next_pend_br    = r_pend_br;
    w_next_pend_pc    = r_pend_pc;
    w_req             = 1'b0;
    w_fv              = 1'b0;
    w_accept          = 1'b0;
    case (r_state)
      S_BOOT: w_next_state = S_FETCH;
      S_FETCH: begin
        w_req    = 1'b1;
        w_accept = pcSrc | w_jump_ok;
        if (imemReady) begin
          w_fv = 1'b1;
          if (w_accept)          w_next_pc = w_tgt;
          else if (weFromHazard) w_next_pc = w_step;
        end else begin
          w_next_state = S_MISS;
          if (w_accept) begin
            w_next_pend_valid = 1'b1;
            w_next_pend_br    = pcSrc;
            w_next_pend_pc    = w_tgt;
          end
        end
      end
      S_MISS: begin
        w_req = 1'b1;
        // A pending branch outranks any later jump; anything else is replaced by the newest redirect.
        w_accept = pcSrc | (w_jump_ok & ~(r_pend_valid & r_pend_br));
        if (w_accept) begin
          w_next_pend_valid = 1'b1;
          w_next_pend_br    = pcSrc;
          w_next_pend_pc    = w_tgt;
        end
        if (imemReady) begin
          w_next_state      = S_FETCH;
          w_next_pend_valid = 1'b0;
          w_next_pend_br    = 1'b0;
          if (r_pend_valid) begin
            w_next_pc = w_accept ? w_tgt : r_pend_pc;
          end else begin
            w_fv = 1'b1;
            if (w_accept)          w_next_pc = w_tgt;
            else if (weFromHazard) w_next_pc = w_step;
          end
        end
      end
      default: w_next_state = S_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_br    <= 1'b0;
      r_pend_pc    <= RESET_PC;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      r_pend_valid <= w_next_pend_valid;
      r_pend_br    <= w_next_pend_br;
      r_pend_pc    <= w_next_pend_pc;
    end
  end

  assign imemReq    = w_req & ~rst;
  assign imemAddr   = r_pc;
  assign pc         = r_pc;
  assign fetchValid = w_fv & ~rst;
  assign flushIfId  = w_accept & ~rst;
  assign flushIdEx  = w_accept & pcSrc & ~rst;
  assign dbgState   = r_state;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count, r_redirect_count;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_fetch_count    <= 32'd0;
      r_redirect_count <= 32'd0;
    end else begin
      if (w_fv)     r_fetch_count    <= r_fetch_count + 32'd1;
      if (w_accept) r_redirect_count <= r_redirect_count + 32'd1;
    end
  end

  assign fetchCount    = r_fetch_count;
  assign redirectCount = r_redirect_count;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed walk through the fetch scenarios, then randomized traffic,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP  = 4;
  localparam int          W        = 68;

  logic        clock, rst, weFromHazard, pcSrc, jump, imemReady;
  logic [31:0] pcBranch, pcJump;
  logic        imemReq, fetchValid, flushIfId, flushIdEx;
  logic [31:0] imemAddr, pc;
  logic [1:0]  dbgState;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount, redirectCount;
`endif

  fetch_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clock(clock), .rst(rst), .weFromHazard(weFromHazard), .pcSrc(pcSrc),
    .pcBranch(pcBranch), .jump(jump), .pcJump(pcJump), .imemReq(imemReq),
    .imemAddr(imemAddr), .imemReady(imemReady), .pc(pc), .fetchValid(fetchValid),
    .flushIfId(flushIfId), .flushIdEx(flushIdEx), .dbgState(dbgState)
`ifdef FETCH_PERF_EN
    , .fetchCount(fetchCount), .redirectCount(redirectCount)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state: PC, boot flag, outstanding-miss flag and at most one pending redirect
  typedef struct {
    logic [31:0] tgt;
    bit          is_br;
  } redir_t;

  logic [31:0] m_pc;
  bit          m_boot, m_miss;
  redir_t      m_pend[$];
  logic [W-1:0] exp_q[$];
  int checks = 0, errors = 0, cyc = 0;

  task automatic model_step();
    logic        e_fv, e_fi, e_fe, acc;
    logic [31:0] n_pc, tgt;
    redir_t      r;
    e_fv = 1'b0; e_fi = 1'b0; e_fe = 1'b0;
    n_pc = m_pc;
    if (rst) begin
      exp_q.push_back({1'b0, m_pc, m_pc, 3'b000});
      m_pc = RESET_PC; m_boot = 1'b1; m_miss = 1'b0; m_pend.delete();
    end else if (m_boot) begin
      exp_q.push_back({1'b0, m_pc, m_pc, 3'b000});
      m_boot = 1'b0;
    end else begin
      acc = pcSrc || (jump && weFromHazard &&
                      !(m_miss && m_pend.size() > 0 && m_pend[0].is_br));
      tgt = pcSrc ? (pcBranch & 32'hFFFF_FFFC) : (pcJump & 32'hFFFF_FFFC);
      e_fi = acc;
      e_fe = acc && pcSrc;
      if (imemReady) begin
        if (m_miss && m_pend.size() > 0) begin
          n_pc = acc ? tgt : m_pend[0].tgt;
        end else begin
          e_fv = 1'b1;
          n_pc = acc ? tgt : (weFromHazard ? 32'(m_pc + PC_STEP) : m_pc);
        end
        m_miss = 1'b0;
        m_pend.delete();
      end else begin
        if (acc) begin
          r.tgt = tgt; r.is_br = pcSrc;
          m_pend.delete();
          m_pend.push_back(r);
        end
        m_miss = 1'b1;
      end
      exp_q.push_back({1'b1, m_pc, m_pc, e_fv, e_fi, e_fe});
      m_pc = n_pc;
    end
  endtask

  // driver: inputs change 1 time unit after the rising edge
  task automatic drive_cycle(input bit r, input bit we, input bit src, input logic [31:0] bt,
                             input bit j, input logic [31:0] jt, input bit rdy);
    @(posedge clock);
    #1;
    rst = r; weFromHazard = we; pcSrc = src; pcBranch = bt;
    jump = j; pcJump = jt; imemReady = rdy;
    cyc++;
    model_step();
  endtask

  // monitor: compares on the falling edge, also guards address stability during a miss
  logic [W-1:0] got, exp_v;
  logic         p_req, p_rdy;
  logic [31:0]  p_addr;
  initial begin p_req = 1'b0; p_rdy = 1'b1; p_addr = 32'h0; end

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got = {imemReq, imemAddr, pc, fetchValid, flushIfId, flushIdEx};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL outputs cyc=%0d got req=%0b addr=%h pc=%h fv=%0b fi=%0b fe=%0b exp req=%0b addr=%h pc=%h fv=%0b fi=%0b fe=%0b",
                 cyc, got[67], got[66:35], got[34:3], got[2], got[1], got[0],
                 exp_v[67], exp_v[66:35], exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
      end
      if (p_req && !p_rdy && imemReq) begin
        checks++;
        if (imemAddr !== p_addr) begin
          errors++;
          $display("FAIL addr_hold cyc=%0d got %h exp %h", cyc, imemAddr, p_addr);
        end
      end
      p_req = imemReq; p_rdy = imemReady; p_addr = imemAddr;
    end
  end

  initial begin
    rst = 1'b1; weFromHazard = 1'b1; pcSrc = 1'b0; pcBranch = 32'h0;
    jump = 1'b0; pcJump = 32'h0; imemReady = 1'b1;
    repeat (2) @(posedge clock);
    m_pc = RESET_PC; m_boot = 1'b1; m_miss = 1'b0;

    // reset, boot, sequential fetch, then a two-cycle stall at pc=8
    drive_cycle(1, 1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    // branch+jump together at 0x10, then jump alone to unaligned 0x83
    drive_cycle(0, 1, 1, 32'h40, 1, 32'h83, 1);
    drive_cycle(0, 1, 0, 0, 1, 32'h83, 1);
    drive_cycle(0, 1, 1, 32'h20, 0, 0, 1);
    // three-cycle miss at 0x20
    drive_cycle(0, 1, 0, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    // back to 0x20; jump then branch while the miss is outstanding
    drive_cycle(0, 1, 1, 32'h20, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 1, 32'h200, 0);
    drive_cycle(0, 1, 1, 32'h100, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    // wrap at the top of the address space
    drive_cycle(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    // reset in the middle of a miss; the late ready lands in BOOT
    drive_cycle(0, 1, 0, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);
    drive_cycle(0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
                  $urandom_range(0, 99) < 12, $urandom(),
                  $urandom_range(0, 99) < 18, $urandom(),
                  $urandom_range(0, 99) < 65);
    end

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Next-PC arbiter and fetch sequencer for the 5-stage pipeline. Owns the architectural PC and chooses the next PC each cycle from three sources: sequential, decode jump, or EX/MEM branch. Drives the instruction-memory request handshake and holds the request stable across multi-cycle misses. Generates the IF/ID and ID/EX flush strobes for taken control transfers.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
PC_STEP, 4, sequential increment in bytes

Ports:
clock  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
weFromHazard  in  1  hazard-unit enable; 0 = stall fetch/decode
pcSrc  in  1  taken branch resolved in EX/MEM
pcBranch  in  32  branch target from EX/MEM
jump  in  1  jump decoded in ID
pcJump  in  32  jump target from IF/ID
imemReq  out  1  instruction fetch request
imemAddr  out  32  fetch address, equal to pc
imemReady  in  1  instruction data valid for the current request
pc  out  32  current fetch PC
fetchValid  out  1  instruction returned this cycle is valid for IF/ID
flushIfId  out  1  squash IF/ID register
flushIdEx  out  1  squash ID/EX register

Behaviour:
- Reset (rst=1 at a clock edge) wins over everything. pc=RESET_PC, state=BOOT, pending cleared. imemReq, fetchValid, flushIfId and flushIdEx are 0 while rst=1 and in BOOT.
- Targets are word-aligned before use: bits [1:0] forced to 0. Sequential next PC is pc+PC_STEP modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- Redirect priority: branch (pcSrc) > jump > sequential.
  - A branch applies regardless of weFromHazard.
  - A jump applies only when weFromHazard=1.
  - A sequential step applies only when weFromHazard=1 and the fetch completed.
- Flushes are combinational in the redirect cycle.
  - Accepted branch: flushIfId=1 and flushIdEx=1.
  - Accepted jump with no branch: flushIfId=1 only.
  - Never asserted in BOOT.
- Memory rule: while imemReq=1 and imemReady=0, imemAddr must not change.
- FSM:
  - BOOT (1 cycle): imemReq=0. Next state is FETCH.
  - FETCH: imemReq=1, imemAddr=pc.
    - imemReady=1: fetchValid=1; pc is updated by the priority rule; stay in FETCH.
    - imemReady=0 with a redirect present: capture it into pendingPc/pendingValid, assert its flushes, pc unchanged, go to MISS.
    - imemReady=0 with no redirect: go to MISS.
  - MISS: imemReq=1, imemAddr held, fetchValid=0.
    - A redirect arriving here is captured into pending. A branch overwrites a pending jump; a jump never overwrites a pending branch. Its flushes assert in the arrival cycle.
    - imemReady=1 with pending set: the returned data is discarded (fetchValid=0), pc=pendingPc, pending cleared, go to FETCH.
    - imemReady=1 with no pending: fetchValid=1, pc updated per the FETCH rules, go to FETCH.
- Simultaneous branch and jump: the branch target is taken, and both flushes assert.
- Stalled with no redirect: pc holds, the request repeats at the same address, and fetchValid follows imemReady.
- Reset during MISS: the outstanding request is abandoned. imemReq=0 from the next cycle.
- Latency: a redirect accepted at edge N gives imemAddr equal to the target in cycle N+1.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetchCount[31:0] and redirectCount[31:0], both reset to 0.
  - fetchCount increments each cycle fetchValid=1.
  - redirectCount increments per accepted branch or jump, counted once even when captured as pending.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent. Core behaviour is identical either way.

Test Plan:
1. Reset, weFromHazard=1, imemReady=1 -> one BOOT cycle with imemReq=0, then pc = 0,4,8,0xC on consecutive cycles with fetchValid=1.
2. At pc=8, weFromHazard=0 for 2 cycles -> pc stays 8 for both cycles, imemAddr=8, no flush; pc=0xC after release.
3. At pc=0x10, pcSrc=1 pcBranch=0x40 together with jump=1 pcJump=0x83 -> next pc=0x40, flushIfId=1 and flushIdEx=1 that cycle; in a separate case jump alone gives pc=0x80 with flushIfId=1 only.
4. At pc=0x20, imemReady=0 for 3 cycles -> imemAddr stable at 0x20, fetchValid=0; on ready, fetchValid=1 and next pc=0x24.
5. In the second miss cycle at pc=0x20: jump to 0x200, then branch to 0x100 one cycle later -> on ready, fetchValid=0, pc=0x100, next imemAddr=0x100.
6. pc=0xFFFFFFFC with a fetch completing -> pc=0x00000000; rst asserted mid-MISS -> pc=RESET_PC, imemReq=0 in BOOT, and the late imemReady is ignored.
